// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory-access stage: bus widths, load-op bit
// positions and the packed layout of the execute-to-memory bus.
package mem_stage_pkg;

    localparam int ES_TO_MS_BUS_WD = 78;
    localparam int MS_TO_WS_BUS_WD = 70;
    localparam int MS_TO_ES_BUS_WD = 32;
    localparam int MS_TO_FW_BUS_WD = 6;

    // Bit positions inside the one-hot load_op field.
    localparam int LD_B  = 0;
    localparam int LD_H  = 1;
    localparam int LD_W  = 2;
    localparam int LD_BU = 3;
    localparam int LD_HU = 4;

    // Field layout of es_to_ms_bus, most significant field first.
    typedef struct packed {
        logic [1:0]  div_op;      // [0] quotient, [1] remainder
        logic [4:0]  load_op;     // one-hot, indexed by LD_*
        logic        mem_to_reg;
        logic        reg_we;
        logic [4:0]  dest;
        logic [31:0] alu_result;
        logic [31:0] pc;
    } es_to_ms_t;

endpackage

// File: rtl/mem_stage_load_align.sv
// Combinational load aligner: picks the addressed byte or half-word out of
// the returned SRAM word and sign- or zero-extends it to 32 bits.
// Misaligned halves ignore addr[0]; words ignore addr entirely.
module mem_stage_load_align
    import mem_stage_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr,
    input  logic [4:0]  load_op,
    output logic [31:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Select the addressed lane, then extend according to the load type.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can leave it unassigned and infer a latch.
        byte_sel = rdata[7:0];
        half_sel = addr[1] ? rdata[31:16] : rdata[15:0];
        result   = '0;
        case (addr)
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            2'd3:    byte_sel = rdata[31:24];
            default: byte_sel = rdata[7:0];
        endcase
        if (load_op[LD_B])       result = {{24{byte_sel[7]}}, byte_sel};
        else if (load_op[LD_BU]) result = {24'd0, byte_sel};
        else if (load_op[LD_H])  result = {{16{half_sel[15]}}, half_sel};
        else if (load_op[LD_HU]) result = {16'd0, half_sel};
        else if (load_op[LD_W])  result = rdata;
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage. Registers the execute-to-memory bus under a
// valid/allowin handshake, captures the divider result on entry, aligns load
// data from the synchronous data SRAM and selects the writeback result.
// Optional feature macro: MS_LOAD_HOLD_EN -- keeps the returned load word in a
// hold register so a load survives writeback backpressure. Without it the
// live SRAM data is used, which is only correct while ws_allowin stays 1.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        ws_allowin,
    output logic        ms_allowin,
    input  logic        es_to_ms_valid,
    input  logic [77:0] es_to_ms_bus,
    output logic        ms_to_ws_valid,
    output logic [69:0] ms_to_ws_bus,
    output logic [31:0] ms_to_es_bus,
    output logic [5:0]  ms_to_fw_bus,
    input  logic [31:0] data_sram_rdata,
    input  logic [31:0] div_quotient,
    input  logic [31:0] div_remainder
);

    logic        ms_valid_q, ms_valid_d;
    es_to_ms_t   bus_q, bus_d;
    logic [31:0] div_res_q, div_res_d;
    logic        ms_ready_go;
    logic        ms_load;
    logic [31:0] load_src;
    logic [31:0] load_data;
    logic [31:0] final_result;

    assign ms_ready_go    = 1'b1;
    assign ms_allowin     = !ms_valid_q || (ms_ready_go && ws_allowin);
    assign ms_to_ws_valid = ms_valid_q && ms_ready_go;
    assign ms_load        = es_to_ms_valid && ms_allowin;

    // Next state of the valid bit, the payload and the captured divider result.
    always_comb begin
        ms_valid_d = ms_valid_q;
        bus_d      = bus_q;
        div_res_d  = div_res_q;
        if (ms_allowin) begin
            ms_valid_d = es_to_ms_valid;
        end
        if (ms_load) begin
            bus_d = es_to_ms_t'(es_to_ms_bus);
            if (bus_d.div_op[0])      div_res_d = div_quotient;
            else if (bus_d.div_op[1]) div_res_d = div_remainder;
        end
    end

    // Stage registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values regardless of block order.
        if (!resetn) begin
            ms_valid_q <= 1'b0;
            bus_q      <= '0;
            div_res_q  <= '0;
        end else begin
            ms_valid_q <= ms_valid_d;
            bus_q      <= bus_d;
            div_res_q  <= div_res_d;
        end
    end

`ifdef MS_LOAD_HOLD_EN
    logic        hold_flag_q, hold_flag_d;
    logic [31:0] hold_q, hold_d;

    // Latch the SRAM word on the first stalled cycle of a load; release on handoff.
    always_comb begin
        hold_flag_d = hold_flag_q;
        hold_d      = hold_q;
        if (ms_to_ws_valid && ws_allowin) begin
            hold_flag_d = 1'b0;
        end else if (ms_valid_q && bus_q.mem_to_reg && !ws_allowin && !hold_flag_q) begin
            hold_flag_d = 1'b1;
            hold_d      = data_sram_rdata;
        end
    end

    // Hold register and flag with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            hold_flag_q <= 1'b0;
            hold_q      <= '0;
        end else begin
            hold_flag_q <= hold_flag_d;
            hold_q      <= hold_d;
        end
    end

    assign load_src = hold_flag_q ? hold_q : data_sram_rdata;
`else
    assign load_src = data_sram_rdata;
`endif

    mem_stage_load_align u_load_align (
        .rdata   (load_src),
        .addr    (bus_q.alu_result[1:0]),
        .load_op (bus_q.load_op),
        .result  (load_data)
    );

    // Writeback result: divider beats load beats plain ALU result.
    always_comb begin
        final_result = bus_q.alu_result;
        if (bus_q.div_op != 2'b00)  final_result = div_res_q;
        else if (bus_q.mem_to_reg)  final_result = load_data;
    end

    assign ms_to_ws_bus = {bus_q.reg_we, bus_q.dest, final_result, bus_q.pc};
    assign ms_to_es_bus = final_result;
    assign ms_to_fw_bus = {bus_q.dest, bus_q.reg_we && ms_valid_q};

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: the driver predicts each accepted
// instruction's writeback bus from a behavioural model and queues it; a
// negedge monitor compares whatever the stage presents against the queue.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        ws_allowin = 1'b1;
    logic        ms_allowin;
    logic        es_to_ms_valid = 1'b0;
    logic [77:0] es_to_ms_bus = '0;
    logic        ms_to_ws_valid;
    logic [69:0] ms_to_ws_bus;
    logic [31:0] ms_to_es_bus;
    logic [5:0]  ms_to_fw_bus;
    logic [31:0] data_sram_rdata = '0;
    logic [31:0] div_quotient = '0;
    logic [31:0] div_remainder = '0;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk             (clk),
        .resetn          (resetn),
        .ws_allowin      (ws_allowin),
        .ms_allowin      (ms_allowin),
        .es_to_ms_valid  (es_to_ms_valid),
        .es_to_ms_bus    (es_to_ms_bus),
        .ms_to_ws_valid  (ms_to_ws_valid),
        .ms_to_ws_bus    (ms_to_ws_bus),
        .ms_to_es_bus    (ms_to_es_bus),
        .ms_to_fw_bus    (ms_to_fw_bus),
        .data_sram_rdata (data_sram_rdata),
        .div_quotient    (div_quotient),
        .div_remainder   (div_remainder)
    );

    typedef struct {
        logic [69:0] ws_bus;
        logic [5:0]  fw;
    } exp_t;

    exp_t exp_q[$];
    logic m_valid = 1'b0;
    int   vecs = 0;
    int   errs = 0;

    task automatic check(input string name, input logic [69:0] act, input logic [69:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference load semantics computed with shifts and plain arithmetic.
    function automatic logic [31:0] ref_load(input logic [4:0] op, input logic [1:0] a,
                                             input logic [31:0] w);
        logic [31:0] b;
        logic [31:0] h;
        b = (w >> (8 * a)) & 32'hFF;
        h = (w >> (16 * a[1])) & 32'hFFFF;
        if (op[0]) return (b >= 32'd128) ? b - 32'd256 : b;
        if (op[3]) return b;
        if (op[1]) return (h >= 32'd32768) ? h - 32'd65536 : h;
        if (op[4]) return h;
        if (op[2]) return w;
        return 32'd0;
    endfunction

    function automatic exp_t expect_of(input logic [77:0] b, input logic [31:0] rd,
                                       input logic [31:0] q, input logic [31:0] r);
        exp_t        e;
        logic [31:0] fin;
        if (b[77:76] == 2'b01)      fin = q;
        else if (b[77:76] == 2'b10) fin = r;
        else if (b[70])             fin = ref_load(b[75:71], b[33:32], rd);
        else                        fin = b[63:32];
        e.ws_bus = {b[69], b[68:64], fin, b[31:0]};
        e.fw     = {b[68:64], b[69]};
        return e;
    endfunction

    function automatic logic [77:0] mk(input logic [1:0] dop, input logic [4:0] lop,
                                       input logic m2r, input logic we, input logic [4:0] dest,
                                       input logic [31:0] alu, input logic [31:0] pc);
        return {dop, lop, m2r, we, dest, alu, pc};
    endfunction

    // One clock of stimulus; rd is the SRAM word returned the cycle after acceptance.
    task automatic step(input logic v, input logic [77:0] bus, input logic [31:0] rd,
                        input logic [31:0] q, input logic [31:0] r, input logic ws);
        logic acc;
        es_to_ms_valid = v;
        es_to_ms_bus   = bus;
        div_quotient   = q;
        div_remainder  = r;
        ws_allowin     = ws;
        acc = v && (!m_valid || ws);
        if (acc) exp_q.push_back(expect_of(bus, rd, q, r));
        @(posedge clk);
        if (!m_valid || ws) m_valid = v;
        #1;
        if (acc) data_sram_rdata = rd;
`ifdef MS_LOAD_HOLD_EN
        else data_sram_rdata = $urandom;
`endif
    endtask

    // Monitor: compare presented outputs against the model every cycle.
    always @(negedge clk) begin
        if (resetn) begin
            check("ms_allowin", 70'(ms_allowin), 70'(!m_valid || ws_allowin));
            check("ms_to_ws_valid", 70'(ms_to_ws_valid), 70'(m_valid));
            if (m_valid) begin
                if (exp_q.size() == 0) begin
                    vecs++;
                    errs++;
                    $display("FAIL scoreboard_empty: got valid output, expected none queued");
                end else begin
                    check("ms_to_ws_bus", ms_to_ws_bus, exp_q[0].ws_bus);
                    check("ms_to_es_bus", 70'(ms_to_es_bus), 70'(exp_q[0].ws_bus[63:32]));
                    check("ms_to_fw_bus", 70'(ms_to_fw_bus), 70'(exp_q[0].fw));
                    if (ws_allowin) void'(exp_q.pop_front());
                end
            end
        end
    end

    localparam logic [31:0] LD_WORD = 32'h80FF_7F01;

    initial begin
        // Power-on reset.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_valid", 70'(ms_to_ws_valid), 70'd0);
        check("reset_ws_bus", ms_to_ws_bus, 70'd0);
        check("reset_fw_bus", 70'(ms_to_fw_bus), 70'd0);
        @(posedge clk);
        #1 resetn = 1'b1;

        // ALU passthrough.
        step(1, mk(2'b00, 5'b00000, 0, 1, 5'd5, 32'h1234_5678, 32'h0000_1000), 0, 0, 0, 1);
        // Loads on one SRAM word: ld.b a=3, ld.bu a=3, ld.h a=2, ld.hu a=0, ld.w a=1.
        step(1, mk(2'b00, 5'b00001, 1, 1, 5'd1, 32'h0000_0103, 32'h0000_1004), LD_WORD, 0, 0, 1);
        step(1, mk(2'b00, 5'b01000, 1, 1, 5'd2, 32'h0000_0203, 32'h0000_1008), LD_WORD, 0, 0, 1);
        step(1, mk(2'b00, 5'b00010, 1, 1, 5'd3, 32'h0000_0302, 32'h0000_100C), LD_WORD, 0, 0, 1);
        step(1, mk(2'b00, 5'b10000, 1, 1, 5'd4, 32'h0000_0400, 32'h0000_1010), LD_WORD, 0, 0, 1);
        step(1, mk(2'b00, 5'b00100, 1, 1, 5'd6, 32'h0000_0501, 32'h0000_1014), LD_WORD, 0, 0, 1);
        // Divider quotient then remainder; later divider changes must not leak in.
        step(1, mk(2'b01, 5'b00000, 0, 1, 5'd7, 32'hAAAA_0000, 32'h0000_1018), 0, 7, 3, 1);
        step(1, mk(2'b10, 5'b00000, 1, 1, 5'd8, 32'hBBBB_0000, 32'h0000_101C), 0, 7, 3, 1);
        step(0, '0, 0, 32'd99, 32'd98, 0);
        step(0, '0, 0, 32'd55, 32'd44, 0);
        step(0, '0, 0, 0, 0, 1);
        // Backpressure: B is offered while A stalls, then both pass in order.
        step(1, mk(2'b00, 5'b00000, 0, 1, 5'd10, 32'h0A0A_0A0A, 32'h0000_2000), 0, 0, 0, 1);
        step(1, mk(2'b00, 5'b00000, 0, 1, 5'd11, 32'h0B0B_0B0B, 32'h0000_2004), 0, 0, 0, 0);
        step(1, mk(2'b00, 5'b00000, 0, 1, 5'd11, 32'h0B0B_0B0B, 32'h0000_2004), 0, 0, 0, 0);
        step(1, mk(2'b00, 5'b00000, 0, 1, 5'd11, 32'h0B0B_0B0B, 32'h0000_2004), 0, 0, 0, 1);
        step(0, '0, 0, 0, 0, 1);
        // Load held under three stalled cycles.
        step(1, mk(2'b00, 5'b00100, 1, 1, 5'd12, 32'h0000_3000, 32'h0000_3000), 32'hDEAD_BEEF, 0, 0, 1);
        repeat (3) step(0, '0, 0, 0, 0, 0);
        step(0, '0, 0, 0, 0, 1);

        // Randomised traffic with random backpressure.
        for (int i = 0; i < 400; i++) begin
            logic [1:0] dop;
            logic [4:0] lop;
            dop = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 2)) : 2'b00;
            lop = 5'(5'b00001 << $urandom_range(0, 4));
            step($urandom_range(0, 9) < 7,
                 mk(dop, lop, 1'($urandom), 1'($urandom), 5'($urandom), $urandom, $urandom),
                 $urandom, $urandom, $urandom, $urandom_range(0, 9) < 7);
        end
        step(0, '0, 0, 0, 0, 1);
        step(0, '0, 0, 0, 0, 1);
        check("drain_queue", 70'(exp_q.size()), 70'd0);

        // Reset while an instruction is stalled in the stage.
        step(1, mk(2'b00, 5'b00000, 0, 1, 5'd9, 32'hCAFE_0000, 32'h0000_4000), 0, 0, 0, 1);
        step(0, '0, 0, 0, 0, 0);
        resetn = 1'b0;
        @(posedge clk);
        m_valid = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("midreset_valid", 70'(ms_to_ws_valid), 70'd0);
        check("midreset_fw0", 70'(ms_to_fw_bus[0]), 70'd0);
        check("midreset_ws_bus", ms_to_ws_bus, 70'd0);
        @(posedge clk);
        #1 resetn = 1'b1;
        step(1, mk(2'b00, 5'b00000, 0, 0, 5'd3, 32'h5555_AAAA, 32'h0000_5000), 0, 0, 0, 1);
        step(0, '0, 0, 0, 0, 1);
        step(0, '0, 0, 0, 0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
